// File: rtl/hs32_intctl.sv
// hs32 interrupt controller: latches 24 edge-detected lines, requests the highest-priority
// enabled one with its handler address and holds it until iack. Option: HS32_INTCTL_LEVEL_EN (level-mode lines).
module hs32_intctl #(
  parameter int NLINES = 24
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [NLINES-1:0] irq_core,
  input  logic [NLINES-1:0] irq_ext,
  input  logic              nmi_in,
  input  logic              iack,
  output logic              intrq,
  output logic [4:0]        vec,
  output logic [31:0]       handler,
  output logic              nmi,
  input  logic              cfg_stb,
  input  logic              cfg_rw,
  input  logic [4:0]        cfg_addr,
  input  logic [31:0]       cfg_din,
  output logic [31:0]       cfg_dout,
  output logic              cfg_ack
);

  localparam logic [4:0]        A_ENABLE  = 5'd24;
  localparam logic [4:0]        A_PENDING = 5'd25;
  localparam logic [4:0]        A_STATUS  = 5'd26;
  localparam logic [4:0]        A_TRIG    = 5'd27;
  localparam logic [NLINES-1:0] LINE0     = {{(NLINES-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            r_state;
  logic              r_intrq;
  logic              r_nmi;
  logic [4:0]        r_vec;
  logic [31:0]       r_handler;
  logic [NLINES-1:0] r_src;
  logic [NLINES-1:0] r_src_prev;
  logic              r_armed;
  logic [NLINES-1:0] r_pending;
  logic [NLINES-1:0] r_enable;
  logic [31:0]       r_table [NLINES];
  logic              r_cfg_ack;
  logic [31:0]       r_cfg_dout;

  logic [NLINES-1:0] w_src;
  logic [NLINES-1:0] w_set;
  logic [NLINES-1:0] w_w1c;
  logic [NLINES-1:0] w_iack_clr;
  logic [NLINES-1:0] w_elig;
  logic [4:0]        w_idx;
  logic              w_any;
  logic              w_wr;
  logic [31:0]       w_rdata;

  assign w_src = irq_core | irq_ext | (nmi_in ? LINE0 : '0);
  assign w_wr  = cfg_stb & cfg_rw;

  // First sample after reset only seeds the history, so a line already high is not an edge.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_src      <= '0;
      r_src_prev <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_src      <= w_src;
      r_src_prev <= r_armed ? r_src : w_src;
      r_armed    <= 1'b1;
    end
  end

`ifdef HS32_INTCTL_LEVEL_EN
  logic [NLINES-1:0] r_trig;
  assign w_set = (r_src & ~r_src_prev) | (r_src & r_trig & ~LINE0);
`else
  assign w_set = r_src & ~r_src_prev;
`endif

  assign w_w1c      = (w_wr && cfg_addr == A_PENDING) ? cfg_din[NLINES-1:0] : '0;
  assign w_iack_clr = (r_state == S_REQ && iack) ? (LINE0 << r_vec) : '0;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) r_pending <= '0;
    else       r_pending <= (r_pending & ~(w_w1c | w_iack_clr)) | w_set;
  end

  assign w_elig = r_pending & (r_enable | LINE0);
  assign w_any  = |w_elig;

  always_comb begin
    w_idx = 5'd0;
    for (int i = NLINES - 1; i >= 0; i--)
      if (w_elig[i]) w_idx = 5'(i);
  end

  always_comb begin
    w_rdata = 32'd0;
    if (cfg_addr < 5'(NLINES)) begin
      w_rdata = r_table[cfg_addr];
    end else begin
      case (cfg_addr)
        A_ENABLE:  w_rdata = {{(32-NLINES){1'b0}}, r_enable};
        A_PENDING: w_rdata = {{(32-NLINES){1'b0}}, r_pending};
        A_STATUS:  w_rdata = {r_intrq, 26'd0, r_vec};
`ifdef HS32_INTCTL_LEVEL_EN
        A_TRIG:    w_rdata = {{(32-NLINES){1'b0}}, r_trig};
`endif
        default:   w_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_enable   <= '0;
      r_cfg_ack  <= 1'b0;
      r_cfg_dout <= 32'd0;
`ifdef HS32_INTCTL_LEVEL_EN
      r_trig     <= '0;
`endif
      for (int i = 0; i < NLINES; i++) r_table[i] <= 32'd0;
    end else begin
      r_cfg_ack <= cfg_stb;
      if (cfg_stb) r_cfg_dout <= w_rdata;
      if (w_wr) begin
        if (cfg_addr < 5'(NLINES)) r_table[cfg_addr] <= cfg_din;
        if (cfg_addr == A_ENABLE)  r_enable <= cfg_din[NLINES-1:0];
`ifdef HS32_INTCTL_LEVEL_EN
        if (cfg_addr == A_TRIG)    r_trig <= cfg_din[NLINES-1:0];
`endif
      end
    end
  end

  // Request outputs are captured once in IDLE and frozen in REQ regardless of config writes.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_intrq   <= 1'b0;
      r_nmi     <= 1'b0;
      r_vec     <= 5'd0;
      r_handler <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_vec     <= w_idx;
          r_handler <= r_table[w_idx];
          r_nmi     <= (w_idx == 5'd0);
          r_intrq   <= 1'b1;
          r_state   <= S_REQ;
        end
        S_REQ: if (iack) begin
          r_intrq <= 1'b0;
          r_nmi   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign intrq    = r_intrq;
  assign nmi      = r_nmi;
  assign vec      = r_vec;
  assign handler  = r_handler;
  assign cfg_ack  = r_cfg_ack;
  assign cfg_dout = r_cfg_dout;

endmodule

// File: tb/tb_hs32_intctl.sv
// Self-checking bench for hs32_intctl: directed test-plan scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_hs32_intctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] irq_core, irq_ext;
  logic        nmi_in, iack;
  logic        cfg_stb, cfg_rw;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_din;
  logic        intrq, nmi, cfg_ack;
  logic [4:0]  vec;
  logic [31:0] handler, cfg_dout;

  hs32_intctl dut (
    .i_clk(clk), .reset(reset), .irq_core(irq_core), .irq_ext(irq_ext),
    .nmi_in(nmi_in), .iack(iack), .intrq(intrq), .vec(vec), .handler(handler),
    .nmi(nmi), .cfg_stb(cfg_stb), .cfg_rw(cfg_rw), .cfg_addr(cfg_addr),
    .cfg_din(cfg_din), .cfg_dout(cfg_dout), .cfg_ack(cfg_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: line history, pending/enable sets, handler table, request state.
  logic [23:0] m_last, m_before;
  int          m_nsamp;
  logic [23:0] m_pend, m_en, m_trig;
  logic [31:0] m_tab [24];
  bit          m_req, m_nmi, m_ack;
  logic [4:0]  m_vec;
  logic [31:0] m_hdl, m_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = '0; m_before = '0; m_nsamp = 0;
    m_pend = '0; m_en = '0; m_trig = '0;
    for (int i = 0; i < 24; i++) m_tab[i] = '0;
    m_req = 0; m_nmi = 0; m_ack = 0; m_vec = '0; m_hdl = '0; m_dout = '0;
  endtask

  task automatic model_update();
    logic [23:0] src, set, clr;
    int          idx;
    logic [31:0] rd;
    src = irq_core | irq_ext | {23'd0, nmi_in};
    set = (m_nsamp >= 2) ? (m_last & ~m_before) : '0;
`ifdef HS32_INTCTL_LEVEL_EN
    if (m_nsamp >= 1) set |= m_last & m_trig & 24'hFFFFFE;
`endif
    clr = '0;
    if (m_req && iack) clr[m_vec] = 1'b1;
    if (cfg_stb && cfg_rw && cfg_addr == 5'd25) clr |= cfg_din[23:0];
    idx = -1;
    for (int i = 23; i >= 0; i--)
      if (m_pend[i] && (m_en[i] || i == 0)) idx = i;
    rd = 0;
    if (cfg_addr < 5'd24) rd = m_tab[cfg_addr];
    else if (cfg_addr == 5'd24) rd = {8'd0, m_en};
    else if (cfg_addr == 5'd25) rd = {8'd0, m_pend};
    else if (cfg_addr == 5'd26) rd = {m_req, 26'd0, m_vec};
`ifdef HS32_INTCTL_LEVEL_EN
    else if (cfg_addr == 5'd27) rd = {8'd0, m_trig};
`endif
    if (!m_req) begin
      if (idx >= 0) begin
        m_req = 1; m_vec = 5'(idx); m_hdl = m_tab[idx]; m_nmi = (idx == 0);
      end
    end else if (iack) begin
      m_req = 0; m_nmi = 0;
    end
    m_ack = cfg_stb;
    if (cfg_stb) m_dout = rd;
    if (cfg_stb && cfg_rw) begin
      if (cfg_addr < 5'd24) m_tab[cfg_addr] = cfg_din;
      if (cfg_addr == 5'd24) m_en = cfg_din[23:0];
`ifdef HS32_INTCTL_LEVEL_EN
      if (cfg_addr == 5'd27) m_trig = cfg_din[23:0];
`endif
    end
    m_pend = (m_pend & ~clr) | set;
    if (m_nsamp == 0) m_before = src; else m_before = m_last;
    m_last = src;
    m_nsamp++;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset(); else model_update();
    #1;
    chk("intrq", {31'd0, intrq}, {31'd0, m_req});
    chk("nmi", {31'd0, nmi}, {31'd0, m_nmi});
    chk("cfg_ack", {31'd0, cfg_ack}, {31'd0, m_ack});
    if (m_req) begin
      chk("vec", {27'd0, vec}, {27'd0, m_vec});
      chk("handler", handler, m_hdl);
    end
    if (m_ack) chk("cfg_dout", cfg_dout, m_dout);
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_stb = 1; cfg_rw = 1; cfg_addr = a; cfg_din = d;
    step();
    cfg_stb = 0; cfg_rw = 0;
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
    cfg_stb = 1; cfg_rw = 0; cfg_addr = a;
    step();
    d = cfg_dout;
    cfg_stb = 0;
  endtask

  initial begin
    logic [31:0] rd;
    reset = 1; irq_core = '0; irq_ext = '0; nmi_in = 0; iack = 0;
    cfg_stb = 0; cfg_rw = 0; cfg_addr = '0; cfg_din = '0;
    model_reset();
    step(); step();
    chk("rst_intrq", {31'd0, intrq}, 32'd0);
    chk("rst_handler", handler, 32'd0);
    reset = 0;

    // Basic request on line 5
    cfg_write(5'd5, 32'h0000_4000);
    cfg_write(5'd24, 32'h20);
    irq_ext[5] = 1; step(); irq_ext[5] = 0;
    step();
    chk("t1_latency_low", {31'd0, intrq}, 32'd0);
    step();
    chk("t1_intrq", {31'd0, intrq}, 32'd1);
    chk("t1_vec", {27'd0, vec}, 32'd5);
    chk("t1_handler", handler, 32'h4000);
    chk("t1_nmi", {31'd0, nmi}, 32'd0);
    chk("t1_model_vec", {27'd0, m_vec}, 32'd5);
    iack = 1; step(); iack = 0;
    chk("t1_drop", {31'd0, intrq}, 32'd0);
    cfg_read(5'd25, rd);
    chk("t1_pending", rd, 32'd0);

    // Priority: lines 3 and 9 together
    cfg_write(5'd24, 32'hFF_FFFF);
    irq_ext = 24'h208; step(); irq_ext = '0;
    step(); step();
    chk("t2_vec3", {27'd0, vec}, 32'd3);
    iack = 1; step(); iack = 0;
    chk("t2_gap", {31'd0, intrq}, 32'd0);
    step();
    chk("t2_intrq9", {31'd0, intrq}, 32'd1);
    chk("t2_vec9", {27'd0, vec}, 32'd9);
    iack = 1; step(); iack = 0;

    // NMI with everything masked
    cfg_write(5'd24, 32'h0);
    cfg_write(5'd0, 32'h100);
    nmi_in = 1; step(); nmi_in = 0;
    step(); step();
    chk("t3_intrq", {31'd0, intrq}, 32'd1);
    chk("t3_nmi", {31'd0, nmi}, 32'd1);
    chk("t3_vec", {27'd0, vec}, 32'd0);
    chk("t3_handler", handler, 32'h100);
    iack = 1; step(); iack = 0;

    // Request held across mask change; masked pending survives
    cfg_write(5'd4, 32'h444);
    cfg_write(5'd24, 32'h12);
    irq_core[4] = 1; step(); step(); step();
    chk("t4_vec4", {27'd0, vec}, 32'd4);
    irq_core[1] = 1; step(); step(); step();
    cfg_write(5'd24, 32'h0);
    chk("t4_hold_vec", {27'd0, vec}, 32'd4);
    chk("t4_hold_hdl", handler, 32'h444);
    iack = 1; step(); iack = 0;
    step(); step();
    chk("t4_masked", {31'd0, intrq}, 32'd0);
    cfg_read(5'd25, rd);
    chk("t4_pending1", rd, 32'h2);
    irq_core = '0;
    cfg_write(5'd25, 32'hFF_FFFF);

    // iack coincident with a new rising edge on the same line
    cfg_write(5'd24, 32'h40);
    irq_ext[6] = 1; step(); irq_ext[6] = 0;
    step(); step();
    chk("t5_vec6", {27'd0, vec}, 32'd6);
    step(); step();
    irq_ext[6] = 1; step();
    iack = 1; step(); iack = 0;
    chk("t5_drop", {31'd0, intrq}, 32'd0);
    cfg_read(5'd25, rd);
    chk("t5_pending", rd, 32'h40);
    chk("t5_rereq", {31'd0, intrq}, 32'd1);
    irq_ext = '0;
    iack = 1; step(); iack = 0;

    // Reset mid-request, line held high through release
    cfg_write(5'd24, 32'h80);
    irq_ext[7] = 1; step(); irq_ext[7] = 0;
    step(); step();
    cfg_read(5'd26, rd);
    chk("t6_status", rd, 32'h8000_0007);
    #2;
    reset = 1; irq_ext = 24'h4;
    #1;
    chk("t6_async_intrq", {31'd0, intrq}, 32'd0);
    chk("t6_async_nmi", {31'd0, nmi}, 32'd0);
    chk("t6_async_vec", {27'd0, vec}, 32'd0);
    chk("t6_async_ack", {31'd0, cfg_ack}, 32'd0);
    chk("t6_async_hdl", handler, 32'd0);
    step(); step();
    reset = 0;
    cfg_read(5'd5, rd);  chk("t6_table5", rd, 32'd0);
    cfg_read(5'd24, rd); chk("t6_enable", rd, 32'd0);
    cfg_read(5'd25, rd); chk("t6_pending", rd, 32'd0);
    cfg_write(5'd24, 32'hFF_FFFF);
    for (int i = 0; i < 5; i++) step();
    chk("t6_no_req", {31'd0, intrq}, 32'd0);
    irq_ext = '0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) irq_ext ^= 24'(1) << $urandom_range(0, 23);
      if ($urandom_range(0, 19) == 0) irq_core ^= 24'(1) << $urandom_range(0, 23);
      nmi_in  = ($urandom_range(0, 60) == 0);
      iack    = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      cfg_stb = ($urandom_range(0, 3) == 0);
      cfg_rw  = ($urandom_range(0, 1) == 1);
      cfg_addr = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(24, 27)) : 5'($urandom_range(0, 31));
      cfg_din = $urandom;
      step();
    end
    iack = 0; cfg_stb = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
